id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- Pipeline register between the ID control-select stage and the EX stage.
- Captures the ID control bundle, operands, immediate, register addresses and PC on each clock edge.
- Supports stall (hold), flush (bubble insertion) and a per-entry valid bit.
- Produces a combinational load-use hazard request back to ID and IF so they can stall.

Parameters:
- DATA_W, 32, width of PC, operand and immediate fields.
- REG_AW, 5, register address width.

Ports:
- CLOCK  input  1  core clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- Stall  input  1  hold the current contents.
- Flush  input  1  load a bubble on the next edge.
- Valid_In  input  1  ID slot holds a real instruction.
- RegWriteEN_In  input  1  register write enable.
- RegSrcSEL_In  input  2  writeback source select: 00 = ALU, 01 = memory.
- MemWriteEN_In  input  1  memory write enable.
- Beq_In, Bne_In  input  1 each  branch type.
- ALUCtrl_In  input  5  ALU operation.
- ALUSrc_In  input  5  ALU source select.
- RegDstSEL_In  input  2  destination select: 00 = Rt, 01 = Rd, 10 = reg 31.
- PC_In, RsData_In, RtData_In, Imm_In  input  DATA_W each  ID datapath values.
- Rs_In, Rt_In, Rd_In  input  REG_AW each  register addresses.
- Every *_In field above has a registered *_Out output of the same width.
- Valid_Out  output  1  EX slot holds a real instruction.
- DstReg_Out  output  REG_AW  resolved destination address, combinational from the registered fields.
- LoadUse_Out  output  1  combinational load-use hazard request.

Behaviour:
- Clock and reset: one clock (CLOCK); RESET is synchronous and active-high, sampled on the CLOCK rising edge.
- Per-edge priority: RESET > Flush > Stall > load.
- RESET = 1 → every registered output clears to 0, including Valid_Out. Values after reset:
  - DstReg_Out = Rt_Out = 0.
  - LoadUse_Out = 0.
- Flush = 1 → bubble:
  - Valid_Out = 0.
  - All control outputs = 0 (RegWriteEN, RegSrcSEL, MemWriteEN, Beq, Bne, ALUCtrl, ALUSrc, RegDstSEL).
  - All data and address outputs = 0.
  - Flush wins over a simultaneous Stall.
- Stall = 1 with Flush = 0 → all registers hold their current value.
- Normal load, Valid_In = 1 → capture all *_In; Valid_Out = 1.
- Normal load, Valid_In = 0 → capture data and address fields; force control outputs to 0; Valid_Out = 0.
  - Result: an invalid entry never writes the register file or memory and never branches.
- Latency: exactly 1 cycle, input to output.
- No internal back-pressure; the entry is always overwritten unless Stall is asserted.
- DstReg_Out decode:
  - RegDstSEL_Out 00 → Rt_Out.
  - 01 → Rd_Out.
  - 10 → 31.
  - 11 → 0.
- LoadUse_Out = 1 only when all of the following hold:
  - Valid_Out = 1, RegWriteEN_Out = 1 and RegSrcSEL_Out = 01;
  - DstReg_Out is not 0;
  - DstReg_Out equals Rs_In or Rt_In, and Valid_In = 1.
- LoadUse_Out is purely combinational, with no register stage. The external controller converts it into Stall to IF/ID and Flush to this block on the same edge. This block does not self-stall.
- Reset mid-operation: RESET overrides any pending Stall or Flush. The first edge with RESET = 0 loads normally.
- Reset value of every output: 0.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- When defined, two DATA_W-bit counters and output ports BubbleCnt_Out and StallCnt_Out are added:
  - BubbleCnt_Out increments on each edge that loads a bubble, either by Flush or by Valid_In = 0 without Stall.
  - StallCnt_Out increments on each edge where Stall = 1 and Flush = 0.
  - Both counters clear on RESET and wrap modulo 2^DATA_W.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Reset: assert RESET for 2 cycles with all inputs = 1 → every output = 0, Valid_Out = 0, LoadUse_Out = 0.
- Load: Valid_In = 1, ALUCtrl_In = 5'h0A, RsData_In = 32'h1234_5678, RegDstSEL_In = 01, Rd_In = 7 → next edge ALUCtrl_Out = 0A, RsData_Out = 32'h1234_5678, DstReg_Out = 7, Valid_Out = 1.
- Stall: Stall = 1 for 3 cycles while the inputs change → outputs unchanged for 3 cycles, then the new values load 1 cycle after Stall drops.
- Flush wins over stall: Flush = 1 and Stall = 1 together, MemWriteEN_In = 1 → next edge MemWriteEN_Out = 0, Valid_Out = 0, all data outputs = 0.
- Load-use:
  - Entry with RegWriteEN = 1, RegSrcSEL = 01, RegDstSEL = 00, Rt = 9; then Rs_In = 9, Valid_In = 1 → LoadUse_Out = 1.
  - Same entry with Rs_In = 9 but Valid_In = 0 → LoadUse_Out = 0.
  - Rt = 0 → LoadUse_Out = 0.
- Perf counters (ID_EX_PERF_EN defined): 4 flush cycles then 2 stall cycles → BubbleCnt_Out = 4, StallCnt_Out = 2; RESET → both 0.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush, per-entry valid and load-use hazard detection.
// Optional ID_EX_PERF_EN adds bubble and stall counters (BubbleCnt_Out, StallCnt_Out).
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              Valid_In,
    input  logic              RegWriteEN_In,
    input  logic [1:0]        RegSrcSEL_In,
    input  logic              MemWriteEN_In,
    input  logic              Beq_In,
    input  logic              Bne_In,
    input  logic [4:0]        ALUCtrl_In,
    input  logic [4:0]        ALUSrc_In,
    input  logic [1:0]        RegDstSEL_In,
    input  logic [DATA_W-1:0] PC_In,
    input  logic [DATA_W-1:0] RsData_In,
    input  logic [DATA_W-1:0] RtData_In,
    input  logic [DATA_W-1:0] Imm_In,
    input  logic [REG_AW-1:0] Rs_In,
    input  logic [REG_AW-1:0] Rt_In,
    input  logic [REG_AW-1:0] Rd_In,
    output logic              Valid_Out,
    output logic              RegWriteEN_Out,
    output logic [1:0]        RegSrcSEL_Out,
    output logic              MemWriteEN_Out,
    output logic              Beq_Out,
    output logic              Bne_Out,
    output logic [4:0]        ALUCtrl_Out,
    output logic [4:0]        ALUSrc_Out,
    output logic [1:0]        RegDstSEL_Out,
    output logic [DATA_W-1:0] PC_Out,
    output logic [DATA_W-1:0] RsData_Out,
    output logic [DATA_W-1:0] RtData_Out,
    output logic [DATA_W-1:0] Imm_Out,
    output logic [REG_AW-1:0] Rs_Out,
    output logic [REG_AW-1:0] Rt_Out,
    output logic [REG_AW-1:0] Rd_Out,
    output logic [REG_AW-1:0] DstReg_Out,
    output logic              LoadUse_Out
`ifdef ID_EX_PERF_EN
    ,
    output logic [DATA_W-1:0] BubbleCnt_Out,
    output logic [DATA_W-1:0] StallCnt_Out
`endif
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [1:0]        reg_src;
        logic              mem_write;
        logic              beq;
        logic              bne;
        logic [4:0]        alu_ctrl;
        logic [4:0]        alu_src;
        logic [1:0]        reg_dst;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
    } entry_t;

    entry_t ent_in, ent_d, ent_q;

    // Invalid slots keep their datapath fields but lose every side-effecting control bit.
    always_comb begin
        ent_in          = '0;
        ent_in.valid    = Valid_In;
        ent_in.pc       = PC_In;
        ent_in.rs_data  = RsData_In;
        ent_in.rt_data  = RtData_In;
        ent_in.imm      = Imm_In;
        ent_in.rs       = Rs_In;
        ent_in.rt       = Rt_In;
        ent_in.rd       = Rd_In;
        if (Valid_In) begin
            ent_in.reg_write = RegWriteEN_In;
            ent_in.reg_src   = RegSrcSEL_In;
            ent_in.mem_write = MemWriteEN_In;
            ent_in.beq       = Beq_In;
            ent_in.bne       = Bne_In;
            ent_in.alu_ctrl  = ALUCtrl_In;
            ent_in.alu_src   = ALUSrc_In;
            ent_in.reg_dst   = RegDstSEL_In;
        end
    end

    always_comb begin
        ent_d = ent_q;
        if (Flush) begin
            ent_d = '0;
        end else if (!Stall) begin
            ent_d = ent_in;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign Valid_Out      = ent_q.valid;
    assign RegWriteEN_Out = ent_q.reg_write;
    assign RegSrcSEL_Out  = ent_q.reg_src;
    assign MemWriteEN_Out = ent_q.mem_write;
    assign Beq_Out        = ent_q.beq;
    assign Bne_Out        = ent_q.bne;
    assign ALUCtrl_Out    = ent_q.alu_ctrl;
    assign ALUSrc_Out     = ent_q.alu_src;
    assign RegDstSEL_Out  = ent_q.reg_dst;
    assign PC_Out         = ent_q.pc;
    assign RsData_Out     = ent_q.rs_data;
    assign RtData_Out     = ent_q.rt_data;
    assign Imm_Out        = ent_q.imm;
    assign Rs_Out         = ent_q.rs;
    assign Rt_Out         = ent_q.rt;
    assign Rd_Out         = ent_q.rd;

    always_comb begin
        DstReg_Out = '0;
        case (ent_q.reg_dst)
            2'b00:   DstReg_Out = ent_q.rt;
            2'b01:   DstReg_Out = ent_q.rd;
            2'b10:   DstReg_Out = REG_AW'(31);
            default: DstReg_Out = '0;
        endcase
    end

    assign LoadUse_Out = ent_q.valid && ent_q.reg_write && (ent_q.reg_src == 2'b01)
                      && (DstReg_Out != '0) && Valid_In
                      && ((DstReg_Out == Rs_In) || (DstReg_Out == Rt_In));

`ifdef ID_EX_PERF_EN
    logic [DATA_W-1:0] bubble_cnt_q, stall_cnt_q;
    logic              bubble_ev, stall_ev;

    assign bubble_ev = Flush || (!Stall && !Valid_In);
    assign stall_ev  = Stall && !Flush;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (bubble_ev) bubble_cnt_q <= bubble_cnt_q + 1'b1;
            if (stall_ev)  stall_cnt_q  <= stall_cnt_q + 1'b1;
        end
    end

    assign BubbleCnt_Out = bubble_cnt_q;
    assign StallCnt_Out  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard testbench for id_ex_pipe_reg; a behavioural model pushes expected entries per edge.
module tb_id_ex_pipe_reg;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          CLOCK = 1'b0;
    logic          RESET, Stall, Flush, Valid_In, RegWriteEN_In, MemWriteEN_In, Beq_In, Bne_In;
    logic [1:0]    RegSrcSEL_In, RegDstSEL_In;
    logic [4:0]    ALUCtrl_In, ALUSrc_In;
    logic [DW-1:0] PC_In, RsData_In, RtData_In, Imm_In;
    logic [AW-1:0] Rs_In, Rt_In, Rd_In;

    logic          Valid_Out, RegWriteEN_Out, MemWriteEN_Out, Beq_Out, Bne_Out, LoadUse_Out;
    logic [1:0]    RegSrcSEL_Out, RegDstSEL_Out;
    logic [4:0]    ALUCtrl_Out, ALUSrc_Out;
    logic [DW-1:0] PC_Out, RsData_Out, RtData_Out, Imm_Out;
    logic [AW-1:0] Rs_Out, Rt_Out, Rd_Out, DstReg_Out;
`ifdef ID_EX_PERF_EN
    logic [DW-1:0] BubbleCnt_Out, StallCnt_Out;
    int unsigned   m_bub = 0, m_stl = 0;
`endif

    id_ex_pipe_reg #(.DATA_W(DW), .REG_AW(AW)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .Stall(Stall), .Flush(Flush), .Valid_In(Valid_In),
        .RegWriteEN_In(RegWriteEN_In), .RegSrcSEL_In(RegSrcSEL_In), .MemWriteEN_In(MemWriteEN_In),
        .Beq_In(Beq_In), .Bne_In(Bne_In), .ALUCtrl_In(ALUCtrl_In), .ALUSrc_In(ALUSrc_In),
        .RegDstSEL_In(RegDstSEL_In), .PC_In(PC_In), .RsData_In(RsData_In), .RtData_In(RtData_In),
        .Imm_In(Imm_In), .Rs_In(Rs_In), .Rt_In(Rt_In), .Rd_In(Rd_In),
        .Valid_Out(Valid_Out), .RegWriteEN_Out(RegWriteEN_Out), .RegSrcSEL_Out(RegSrcSEL_Out),
        .MemWriteEN_Out(MemWriteEN_Out), .Beq_Out(Beq_Out), .Bne_Out(Bne_Out),
        .ALUCtrl_Out(ALUCtrl_Out), .ALUSrc_Out(ALUSrc_Out), .RegDstSEL_Out(RegDstSEL_Out),
        .PC_Out(PC_Out), .RsData_Out(RsData_Out), .RtData_Out(RtData_Out), .Imm_Out(Imm_Out),
        .Rs_Out(Rs_Out), .Rt_Out(Rt_Out), .Rd_Out(Rd_Out), .DstReg_Out(DstReg_Out),
        .LoadUse_Out(LoadUse_Out)
`ifdef ID_EX_PERF_EN
        , .BubbleCnt_Out(BubbleCnt_Out), .StallCnt_Out(StallCnt_Out)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic          valid, regwrite;
        logic [1:0]    regsrc;
        logic          memwrite, beq, bne;
        logic [4:0]    aluctrl, alusrc;
        logic [1:0]    regdst;
        logic [DW-1:0] pc, rsdata, rtdata, imm;
        logic [AW-1:0] rs, rt, rd, dst;
    } obs_t;

    obs_t model_q = '0;
    obs_t sb[$];
    obs_t exp_o, act_o, held;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [AW-1:0] dst_of(input logic [1:0] sel, input logic [AW-1:0] rt,
                                             input logic [AW-1:0] rd);
        if (sel == 2'b00) return rt;
        if (sel == 2'b01) return rd;
        if (sel == 2'b10) return 5'd31;
        return 5'd0;
    endfunction

    function automatic obs_t snap();
        obs_t s;
        s = '{Valid_Out, RegWriteEN_Out, RegSrcSEL_Out, MemWriteEN_Out, Beq_Out, Bne_Out,
              ALUCtrl_Out, ALUSrc_Out, RegDstSEL_Out, PC_Out, RsData_Out, RtData_Out, Imm_Out,
              Rs_Out, Rt_Out, Rd_Out, DstReg_Out};
        return s;
    endfunction

    function automatic logic lu_expected();
        return model_q.valid && model_q.regwrite && model_q.regsrc == 2'b01 && model_q.dst != 0
            && Valid_In && (model_q.dst == Rs_In || model_q.dst == Rt_In);
    endfunction

    // Compute the model's next entry from current inputs, queue it, then advance one edge.
    task automatic tick();
        obs_t n;
        n = '0;
        if (RESET || Flush) begin
            n = '0;
        end else if (Stall) begin
            n = model_q;
        end else begin
            n.valid = Valid_In;
            n.pc = PC_In; n.rsdata = RsData_In; n.rtdata = RtData_In; n.imm = Imm_In;
            n.rs = Rs_In; n.rt = Rt_In; n.rd = Rd_In;
            if (Valid_In) begin
                n.regwrite = RegWriteEN_In; n.regsrc = RegSrcSEL_In; n.memwrite = MemWriteEN_In;
                n.beq = Beq_In; n.bne = Bne_In; n.aluctrl = ALUCtrl_In; n.alusrc = ALUSrc_In;
                n.regdst = RegDstSEL_In;
            end
            n.dst = dst_of(n.regdst, n.rt, n.rd);
        end
`ifdef ID_EX_PERF_EN
        if (RESET) begin
            m_bub = 0; m_stl = 0;
        end else begin
            if (Flush || (!Stall && !Valid_In)) m_bub++;
            if (Stall && !Flush) m_stl++;
        end
`endif
        sb.push_back(n);
        model_q = n;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic rand_inputs();
        Valid_In = 1'($urandom); RegWriteEN_In = 1'($urandom); RegSrcSEL_In = 2'($urandom);
        MemWriteEN_In = 1'($urandom); Beq_In = 1'($urandom); Bne_In = 1'($urandom);
        ALUCtrl_In = 5'($urandom); ALUSrc_In = 5'($urandom); RegDstSEL_In = 2'($urandom);
        PC_In = $urandom; RsData_In = $urandom; RtData_In = $urandom; Imm_In = $urandom;
        Rs_In = 5'($urandom_range(0, 3)); Rt_In = 5'($urandom_range(0, 3));
        Rd_In = 5'($urandom_range(0, 3));
    endtask

    task automatic test_reset();
        RESET = 1; Stall = 1; Flush = 1; Valid_In = 1; RegWriteEN_In = 1; RegSrcSEL_In = '1;
        MemWriteEN_In = 1; Beq_In = 1; Bne_In = 1; ALUCtrl_In = '1; ALUSrc_In = '1;
        RegDstSEL_In = '1; PC_In = '1; RsData_In = '1; RtData_In = '1; Imm_In = '1;
        Rs_In = '1; Rt_In = '1; Rd_In = '1;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_o = sb.pop_front(); act_o = snap(); checks++;
            if (act_o !== exp_o || act_o !== obs_t'('0)) begin
                errors++; $display("FAIL reset: got %h want %h", act_o, exp_o);
            end
            checks++;
            if (LoadUse_Out !== 1'b0) begin
                errors++; $display("FAIL reset_loaduse: got %b want 0", LoadUse_Out);
            end
        end
        RESET = 0; Stall = 0; Flush = 0;
    endtask

    task automatic test_load();
        rand_inputs();
        Valid_In = 1; ALUCtrl_In = 5'h0A; RsData_In = 32'h1234_5678; RegDstSEL_In = 2'b01; Rd_In = 5'd7;
        tick();
        exp_o = sb.pop_front(); act_o = snap(); checks++;
        if (act_o !== exp_o) begin errors++; $display("FAIL load: got %h want %h", act_o, exp_o); end
        checks++;
        if (ALUCtrl_Out !== 5'h0A || RsData_Out !== 32'h1234_5678 || DstReg_Out !== 5'd7 || Valid_Out !== 1'b1) begin
            errors++;
            $display("FAIL load_fields: got alu=%h rs=%h dst=%0d v=%b want 0a 12345678 7 1",
                     ALUCtrl_Out, RsData_Out, DstReg_Out, Valid_Out);
        end
    endtask

    task automatic test_stall();
        rand_inputs(); Valid_In = 1;
        tick();
        exp_o = sb.pop_front(); held = snap(); checks++;
        if (held !== exp_o) begin errors++; $display("FAIL stall_pre: got %h want %h", held, exp_o); end
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            tick();
            exp_o = sb.pop_front(); act_o = snap(); checks++;
            if (act_o !== exp_o || act_o !== held) begin
                errors++; $display("FAIL stall_hold%0d: got %h want %h", i, act_o, held);
            end
        end
        Stall = 0;
        tick();
        exp_o = sb.pop_front(); act_o = snap(); checks++;
        if (act_o !== exp_o) begin errors++; $display("FAIL stall_release: got %h want %h", act_o, exp_o); end
    endtask

    task automatic test_flush();
        rand_inputs(); Valid_In = 1; PC_In = 32'hDEAD_BEEF;
        tick();
        void'(sb.pop_front());
        rand_inputs(); Flush = 1; Stall = 1; MemWriteEN_In = 1; Valid_In = 1;
        tick();
        exp_o = sb.pop_front(); act_o = snap(); checks++;
        if (act_o !== exp_o) begin errors++; $display("FAIL flush: got %h want %h", act_o, exp_o); end
        checks++;
        if (MemWriteEN_Out !== 1'b0 || Valid_Out !== 1'b0 || PC_Out !== '0 || RsData_Out !== '0
            || RtData_Out !== '0 || Imm_Out !== '0) begin
            errors++; $display("FAIL flush_zero: got mw=%b v=%b pc=%h want 0 0 0", MemWriteEN_Out, Valid_Out, PC_Out);
        end
        Flush = 0; Stall = 0;
    endtask

    task automatic test_invalid_and_decode();
        rand_inputs(); Valid_In = 0; RegWriteEN_In = 1; MemWriteEN_In = 1; Beq_In = 1;
        tick();
        exp_o = sb.pop_front(); act_o = snap(); checks++;
        if (act_o !== exp_o) begin errors++; $display("FAIL invalid_load: got %h want %h", act_o, exp_o); end
        for (int s = 2; s < 4; s++) begin
            rand_inputs(); Valid_In = 1; RegDstSEL_In = 2'(s); Rt_In = 5'd5; Rd_In = 5'd6;
            tick();
            exp_o = sb.pop_front(); act_o = snap(); checks++;
            if (act_o !== exp_o || DstReg_Out !== (s == 2 ? 5'd31 : 5'd0)) begin
                errors++; $display("FAIL dst_sel%0d: got %h dst=%0d want %h", s, act_o, DstReg_Out, exp_o);
            end
        end
    endtask

    task automatic test_load_use();
        rand_inputs();
        Valid_In = 1; RegWriteEN_In = 1; RegSrcSEL_In = 2'b01; RegDstSEL_In = 2'b00;
        Rt_In = 5'd9; Rs_In = 5'd3; Rd_In = 5'd4;
        tick();
        exp_o = sb.pop_front(); act_o = snap(); checks++;
        if (act_o !== exp_o) begin errors++; $display("FAIL lu_entry: got %h want %h", act_o, exp_o); end
        Rs_In = 5'd9; Rt_In = 5'd2; Valid_In = 1; #1; checks++;
        if (LoadUse_Out !== 1'b1) begin errors++; $display("FAIL lu_rs: got %b want 1", LoadUse_Out); end
        Valid_In = 0; #1; checks++;
        if (LoadUse_Out !== 1'b0) begin errors++; $display("FAIL lu_invalid: got %b want 0", LoadUse_Out); end
        Rs_In = 5'd2; Rt_In = 5'd9; Valid_In = 1; #1; checks++;
        if (LoadUse_Out !== 1'b1) begin errors++; $display("FAIL lu_rt: got %b want 1", LoadUse_Out); end
        RegWriteEN_In = 1; RegSrcSEL_In = 2'b01; RegDstSEL_In = 2'b00; Rt_In = 5'd0;
        tick();
        void'(sb.pop_front());
        Rs_In = 5'd0; Rt_In = 5'd0; Valid_In = 1; #1; checks++;
        if (LoadUse_Out !== 1'b0) begin errors++; $display("FAIL lu_zero: got %b want 0", LoadUse_Out); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            RESET = ($urandom_range(0, 39) == 0);
            Flush = ($urandom_range(0, 7) == 0);
            Stall = ($urandom_range(0, 4) == 0);
            tick();
            exp_o = sb.pop_front(); act_o = snap(); checks++;
            if (act_o !== exp_o) begin errors++; $display("FAIL b2b%0d: got %h want %h", i, act_o, exp_o); end
            checks++;
            if (LoadUse_Out !== lu_expected()) begin
                errors++; $display("FAIL b2b_lu%0d: got %b want %b", i, LoadUse_Out, lu_expected());
            end
        end
        RESET = 0; Flush = 0; Stall = 0;
    endtask

`ifdef ID_EX_PERF_EN
    task automatic test_perf();
        RESET = 1; tick(); void'(sb.pop_front()); RESET = 0;
        Flush = 1; Stall = 0;
        for (int i = 0; i < 4; i++) begin rand_inputs(); tick(); void'(sb.pop_front()); end
        Flush = 0; Stall = 1;
        for (int i = 0; i < 2; i++) begin rand_inputs(); tick(); void'(sb.pop_front()); end
        checks++;
        if (BubbleCnt_Out !== 32'd4 || StallCnt_Out !== 32'd2 || BubbleCnt_Out !== DW'(m_bub)) begin
            errors++; $display("FAIL perf_count: got b=%0d s=%0d want 4 2", BubbleCnt_Out, StallCnt_Out);
        end
        Stall = 0; RESET = 1; tick(); void'(sb.pop_front()); RESET = 0;
        checks++;
        if (BubbleCnt_Out !== '0 || StallCnt_Out !== '0) begin
            errors++; $display("FAIL perf_reset: got b=%0d s=%0d want 0 0", BubbleCnt_Out, StallCnt_Out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_flush();
        test_invalid_and_decode();
        test_load_use();
        test_back_to_back();
`ifdef ID_EX_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
